sp_ram_pipe: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request port, byte-enable writes, a configurable registered read pipeline and a credit-protected response buffer, so read data is never lost under response backpressure. It replaces fixed 8x1024 block-memory instances wherever a compute stage needs on-chip weight or activation storage with flow control.

---
 rtl/sp_ram_pkg.sv | 17 +
 rtl/sp_ram_resp_fifo.sv | 61 ++++++
 rtl/sp_ram_pipe.sv | 174 +++++++++++++++++
 tb/tb_sp_ram_pipe.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the pipelined single-port RAM: FSM states, latency limits
// and response-buffer sizing (one slot per in-flight read plus the one being presented).
package sp_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sp_ram_state_t;

    localparam int SP_RAM_MIN_LATENCY = 1;
    localparam int SP_RAM_MAX_LATENCY = 4;

    function automatic int sp_ram_resp_depth(input int read_latency);
        return read_latency + 1;
    endfunction

endpackage

// File: rtl/sp_ram_resp_fifo.sv
// First-word fall-through FIFO: an empty FIFO presents in_dat the same cycle (0 added latency).
// No in_rdy: the producer must guarantee space (credit-limited upstream); out_dat holds while out_rdy=0.
module sp_ram_resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             push;
    logic             pop_mem;

    assign empty   = (count == '0);
    assign out_vld = !empty || in_vld;
    assign out_dat = !empty ? mem[rd_ptr] : (in_vld ? in_dat : '0);

    // An entry consumed straight from the input never occupies storage.
    assign push    = in_vld && !(empty && out_rdy);
    assign pop_mem = out_rdy && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_mem) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop_mem})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sp_ram_pipe.sv
// Single-port RAM, valid/ready requests, byte-enable writes; reads return READ_LATENCY cycles after accept.
// req_ready is credit-gated so the response buffer always has room; SP_RAM_CLEAR_EN zero-fills the RAM after reset.
module sp_ram_pipe
    import sp_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    init_done
);

    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int BE_W       = DATA_WIDTH / 8;
    localparam int RESP_DEPTH = sp_ram_resp_depth(READ_LATENCY);
    localparam int CNT_W      = $clog2(RESP_DEPTH + 1);

    if (READ_LATENCY < SP_RAM_MIN_LATENCY || READ_LATENCY > SP_RAM_MAX_LATENCY) begin : g_bad_latency
        $error("sp_ram_pipe: READ_LATENCY must be within 1..4");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("sp_ram_pipe: DATA_WIDTH must be a multiple of 8");
    end

    logic [DATA_WIDTH-1:0]   ram [DEPTH];

    sp_ram_state_t           state_q;
    sp_ram_state_t           state_nxt;
    logic                    init_done_q;
    logic [CNT_W-1:0]        outstanding;

    logic                    rd_acc;
    logic                    wr_acc;
    logic                    resp_pop;

    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [BE_W-1:0]         ram_be;

    logic [READ_LATENCY-1:0] pipe_vld;
    logic [DATA_WIDTH-1:0]   pipe_dat [READ_LATENCY];

    assign req_ready = (state_q == RUN) && init_done_q && (outstanding < CNT_W'(RESP_DEPTH));
    assign rd_acc    = req_valid && req_ready && !req_we;
    assign wr_acc    = req_valid && req_ready && req_we;
    assign resp_pop  = resp_valid && resp_ready;
    assign init_done = init_done_q;

`ifdef SP_RAM_CLEAR_EN
    localparam sp_ram_state_t RESET_STATE = CLEAR;

    logic [ADDR_WIDTH-1:0] clr_addr;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            CLEAR:   if (clr_addr == '1) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_addr <= '0;
        end else if (state_q == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    // The clear walk owns the write port; req_ready is low so no request can collide.
    always_comb begin
        ram_we    = wr_acc;
        ram_waddr = req_addr;
        ram_wdata = req_wdata;
        ram_be    = req_be;
        if (state_q == CLEAR && rst) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
            ram_be    = '1;
        end
    end
`else
    localparam sp_ram_state_t RESET_STATE = RUN;

    always_comb begin
        state_nxt = RUN;
    end

    always_comb begin
        ram_we    = wr_acc;
        ram_waddr = req_addr;
        ram_wdata = req_wdata;
        ram_be    = req_be;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RESET_STATE;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            init_done_q <= (state_nxt == RUN);
        end
    end

    // RAM array is deliberately not reset so contents survive a mid-operation reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (ram_we && ram_be[b]) begin
                ram[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            pipe_dat[0] <= ram[req_addr];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_dat[i] <= pipe_dat[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            outstanding <= '0;
        end else begin
            case ({rd_acc, resp_pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    sp_ram_resp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (pipe_vld[READ_LATENCY-1]),
        .in_dat  (pipe_dat[READ_LATENCY-1]),
        .out_vld (resp_valid),
        .out_rdy (resp_ready),
        .out_dat (resp_rdata)
    );

endmodule

// File: tb/tb_sp_ram_pipe.sv
// Bench for sp_ram_pipe (READ_LATENCY=3, 16 words); honours SP_RAM_CLEAR_EN when defined.
module tb_sp_ram_pipe;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 16;
    localparam int RD    = LAT + 1;
`ifdef SP_RAM_CLEAR_EN
    localparam int INIT_CYC = DEPTH;
`else
    localparam int INIT_CYC = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [3:0]    req_be;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          init_done;

    always #5 clk = ~clk;

    sp_ram_pipe #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_be     (req_be),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .init_done  (init_done)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    int            cyc = 0;
    int            credit = 0;
    int            acc_reads = 0;
    int            last_acc_cyc = -10;
    int            last_pop_cyc = -10;
    int            streak = 0;
    int            max_streak = 0;

    // Observe the handshakes about to happen on the next edge, update the model, then advance.
    task automatic step();
        if (resp_valid && resp_ready) begin
            got_q.push_back(resp_rdata);
            streak = (last_pop_cyc == cyc - 1) ? streak + 1 : 1;
            if (streak > max_streak) max_streak = streak;
            last_pop_cyc = cyc;
            credit--;
        end
        if (req_valid && req_ready && rst) begin
            if (req_we) begin
                for (int b = 0; b < 4; b++)
                    if (req_be[b]) model_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            end else begin
                exp_q.push_back(model_mem[req_addr]);
                last_acc_cyc = cyc;
                acc_reads++;
                credit++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [3:0] be,
                         input logic [DW-1:0] data);
        int   tries = 0;
        logic acc;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = data;
        do begin
            acc = req_ready;
            step();
            tries++;
        end while (!acc && tries < 50);
        idle();
        n_checks++;
        if (!acc) $display("FAIL issue_accept: request at addr %0d not accepted within 50 cycles", addr);
        else n_pass++;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        resp_ready = 1'b1;
        while (got_q.size() < exp_q.size() && n < 100) begin
            step();
            n++;
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        idle();
        resp_ready = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        n_checks += 4;
        if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else n_pass++;
        if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else n_pass++;
        if (resp_rdata !== '0) $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); else n_pass++;
        if (init_done !== 1'b0) $display("FAIL reset_init_done: got %b want 0", init_done); else n_pass++;
        rst = 1'b1;
        begin
            int n = 0;
            while (init_done !== 1'b1 && n < 100) begin
                step();
                n++;
            end
            n_checks += 2;
            if (n != INIT_CYC) $display("FAIL init_latency: got %0d cycles want %0d", n, INIT_CYC); else n_pass++;
            if (req_ready !== 1'b1) $display("FAIL init_req_ready: got %b want 1", req_ready); else n_pass++;
        end
`ifdef SP_RAM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
`endif
        credit = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_init_contents();
`ifdef SP_RAM_CLEAR_EN
        resp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) issue(1'b0, AW'(i), 4'h0, '0);
        drain();
        n_checks++;
        if (got_q.size() != DEPTH) $display("FAIL clear_count: got %0d want %0d", got_q.size(), DEPTH); else n_pass++;
        foreach (got_q[i]) begin
            n_checks++;
            if (got_q[i] !== 32'h0) $display("FAIL clear_word[%0d]: got %h want 0", i, got_q[i]); else n_pass++;
        end
`else
        for (int i = 0; i < DEPTH; i++) issue(1'b1, AW'(i), 4'hF, $urandom);
`endif
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_write_read();
        resp_ready = 1'b1;
        issue(1'b1, 4'd5, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 4'd5, 4'h0, '0);
        drain();
        n_checks += 3;
        if (got_q.size() != 1) $display("FAIL wr_rd_count: got %0d want 1", got_q.size()); else n_pass++;
        if (got_q.size() < 1 || got_q[0] !== 32'hDEADBEEF)
            $display("FAIL wr_rd_data: got %h want deadbeef", got_q.size() ? got_q[0] : 'x);
        else n_pass++;
        if (last_pop_cyc - last_acc_cyc != LAT)
            $display("FAIL wr_rd_latency: got %0d want %0d", last_pop_cyc - last_acc_cyc, LAT);
        else n_pass++;
        got_q.delete();
        exp_q.delete();
        issue(1'b1, 4'd15, 4'hF, 32'h12345678);
        issue(1'b0, 4'd15, 4'h0, '0);
        issue(1'b0, 4'd0, 4'h0, '0);
        drain();
        n_checks += 2;
        if (got_q.size() != 2) $display("FAIL top_addr_count: got %0d want 2", got_q.size()); else n_pass++;
        if (got_q.size() < 1 || got_q[0] !== 32'h12345678)
            $display("FAIL top_addr_data: got %h want 12345678", got_q.size() ? got_q[0] : 'x);
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL top_addr_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_byte_enable();
        resp_ready = 1'b1;
        issue(1'b1, 4'd7, 4'hF, 32'hFFFFFFFF);
        issue(1'b1, 4'd7, 4'b0101, 32'h00000000);
        issue(1'b0, 4'd7, 4'h0, '0);
        drain();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 32'hFF00FF00)
            $display("FAIL byte_enable: got %h (n=%0d) want ff00ff00", got_q.size() ? got_q[0] : 'x, got_q.size());
        else n_pass++;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int bubbles = 0;
        int acc0 = acc_reads;
        max_streak = 0;
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = AW'(i);
            if (req_ready !== 1'b1) bubbles++;
            step();
        end
        drain();
        n_checks += 3;
        if (bubbles != 0) $display("FAIL b2b_bubbles: got %0d want 0", bubbles); else n_pass++;
        if (acc_reads - acc0 != 8) $display("FAIL b2b_accepts: got %0d want 8", acc_reads - acc0); else n_pass++;
        if (max_streak != 8) $display("FAIL b2b_streak: got %0d want 8", max_streak); else n_pass++;
        n_checks++;
        if (got_q.size() != 8) $display("FAIL b2b_count: got %0d want 8", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int acc0 = acc_reads;
        resp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = AW'(i + 3);
            step();
        end
        n_checks += 2;
        if (acc_reads - acc0 != RD) $display("FAIL bp_accepts: got %0d want %0d", acc_reads - acc0, RD); else n_pass++;
        if (req_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", req_ready); else n_pass++;
        idle();
        resp_ready = 1'b1;
        step();
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL bp_ready_rise: got %b want 1", req_ready); else n_pass++;
        drain();
        n_checks++;
        if (got_q.size() != RD) $display("FAIL bp_count: got %0d want %0d", got_q.size(), RD); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_we     = 1'($urandom_range(0, 1));
            req_addr   = AW'($urandom_range(0, DEPTH - 1));
            req_be     = 4'($urandom_range(0, 15));
            req_wdata  = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
            n_checks++;
            if (req_ready !== (credit < RD)) $display("FAIL rand_req_ready cyc %0d: got %b want %b", cyc, req_ready, credit < RD);
            else n_pass++;
            step();
        end
        drain();
        n_checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL rand_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = AW'(i);
            step();
        end
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_q.delete();
        credit = 0;
        n_checks++;
        if (dut.outstanding !== '0) $display("FAIL mid_reset_outstanding: got %0d want 0", dut.outstanding); else n_pass++;
`ifdef SP_RAM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
`endif
        resp_ready = 1'b1;
        repeat (DEPTH + 8) step();
        n_checks++;
        if (got_q.size() != 0) $display("FAIL mid_reset_flush: got %0d responses want 0", got_q.size()); else n_pass++;
        got_q.delete();
        issue(1'b0, 4'd5, 4'h0, '0);
        issue(1'b0, 4'd7, 4'h0, '0);
        issue(1'b0, 4'd15, 4'h0, '0);
        drain();
        n_checks++;
        if (got_q.size() != 3) $display("FAIL mid_reset_count: got %0d want 3", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL mid_reset_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        resp_ready = 1'b0;
        idle();
        test_reset();
        test_init_contents();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
